// File: rtl/icache_mem_pkg.sv
// Shared types and constants for the I-cache refill responder.
package icache_mem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/icache_line_assembler.sv
// Cache-line register: one 32-bit word written per cycle into a selected slot.
module icache_line_assembler
    import icache_mem_pkg::*;
#(
    parameter int unsigned offset_width = 2
) (
    input  logic                                      clk,
    input  logic                                      rstn,
    input  logic                                      we,
    input  logic [offset_width-1:0]                   slot,
    input  logic [WORD_W-1:0]                         wdata,
    output logic [WORD_W*(2**offset_width)-1:0]       line
);

    localparam int unsigned WORDS = 2**offset_width;

    logic [WORDS-1:0][WORD_W-1:0] words;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            words <= '0;
        end else if (we) begin
            words[slot] <= wdata;
        end
    end

    assign line = words;

endmodule

// File: rtl/icache_mem_responder.sv
// Memory-side refill responder: reads one line word-by-word from a sync RAM.
// Optional ICACHE_RESP_DELAY_EN adds delay_cycles wait cycles before dataOK.
module icache_mem_responder
    import icache_mem_pkg::*;
#(
    parameter int unsigned offset_width   = 2,
    parameter int unsigned ram_addr_width = 10,
    parameter int unsigned delay_cycles   = 3
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  icache_mem_req,
    input  logic [1:0]                            icache_mem_size,
    input  logic [31:0]                           icache_mem_addr,
    output logic                                  mem_icache_addrOK,
    output logic                                  mem_icache_dataOK,
    output logic [WORD_W*(2**offset_width)-1:0]   mem_icache_data,
    output logic                                  ram_en,
    output logic [ram_addr_width-1:0]             ram_addr,
    input  logic [WORD_W-1:0]                     ram_rdata
);

    localparam int unsigned WORDS = 2**offset_width;
    localparam int unsigned IDX_W = ram_addr_width - offset_width;
    localparam logic [offset_width-1:0] CNT_LAST = offset_width'(WORDS - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [IDX_W-1:0]          line_idx;
    logic [offset_width-1:0]   cnt;
    logic                      rd_valid;
    logic [offset_width-1:0]   rd_slot;

`ifdef ICACHE_RESP_DELAY_EN
    localparam int unsigned DLY_W = (delay_cycles > 0) ? $clog2(delay_cycles + 1) : 1;
    logic [DLY_W-1:0]          dly;
`endif

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt         = state;
        mem_icache_addrOK = 1'b0;
        mem_icache_dataOK = 1'b0;
        ram_en            = 1'b0;
        case (state)
            IDLE: begin
                mem_icache_addrOK = icache_mem_req;
                if (icache_mem_req) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                ram_en = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
`ifdef ICACHE_RESP_DELAY_EN
                if (dly == '0) begin
                    state_nxt = RESP;
                end
`else
                state_nxt = RESP;
`endif
            end
            RESP: begin
                mem_icache_dataOK = 1'b1;
                state_nxt         = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_addr = ram_en ? {line_idx, cnt} : '0;

    // Line index, word counter and one-cycle-late capture tracking
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_idx <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_slot  <= '0;
        end else begin
            rd_valid <= ram_en;
            rd_slot  <= cnt;
            if (state == IDLE && icache_mem_req) begin
                line_idx <= icache_mem_addr[ram_addr_width+1 : 2+offset_width];
                cnt      <= '0;
            end else if (state == READ) begin
                cnt <= cnt + offset_width'(1);
            end
        end
    end

`ifdef ICACHE_RESP_DELAY_EN
    // Response delay down-counter, loaded as the last word is issued
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dly <= '0;
        end else if (state == READ && cnt == CNT_LAST) begin
            dly <= DLY_W'(delay_cycles);
        end else if (state == WAIT && dly != '0) begin
            dly <= dly - DLY_W'(1);
        end
    end
`endif

    icache_line_assembler #(
        .offset_width (offset_width)
    ) u_line (
        .clk   (clk),
        .rstn  (rstn),
        .we    (rd_valid),
        .slot  (rd_slot),
        .wdata (ram_rdata),
        .line  (mem_icache_data)
    );

    // Size and out-of-range address bits do not matter: every refill is a full aligned line.
    logic unused_inputs;
`ifdef ICACHE_RESP_DELAY_EN
    assign unused_inputs = ^{icache_mem_size == SIZE_B, icache_mem_size == SIZE_H,
                             icache_mem_size == SIZE_W,
                             icache_mem_addr[31:ram_addr_width+2],
                             icache_mem_addr[offset_width+1:0]};
`else
    assign unused_inputs = ^{icache_mem_size == SIZE_B, icache_mem_size == SIZE_H,
                             icache_mem_size == SIZE_W,
                             icache_mem_addr[31:ram_addr_width+2],
                             icache_mem_addr[offset_width+1:0], 32'(delay_cycles)};
`endif

endmodule

// File: tb/tb_icache_mem_responder.sv
// Scoreboard bench for icache_mem_responder; latency follows ICACHE_RESP_DELAY_EN.
module tb_icache_mem_responder;

    localparam int unsigned WORDS = 4;
    localparam int unsigned LW    = 32 * WORDS;
`ifdef ICACHE_RESP_DELAY_EN
    localparam int LAT = 6 + 3;
`else
    localparam int LAT = 6;
`endif
    localparam int PER = LAT + 1;

    typedef struct {
        int            cyc;
        logic [LW-1:0] val;
    } exp_t;

    logic          clk;
    logic          rstn;
    logic          req;
    logic [1:0]    size;
    logic [31:0]   addr;
    logic          addr_ok;
    logic          data_ok;
    logic [LW-1:0] data;
    logic          ram_en;
    logic [9:0]    ram_addr;
    logic [31:0]   ram_rdata;

    logic [31:0]   mem [1024];
    int            cyc;
    int            checks;
    int            errors;
    exp_t          ram_q[$];
    exp_t          resp_q[$];

    icache_mem_responder #(
        .offset_width   (2),
        .ram_addr_width (10),
        .delay_cycles   (3)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .icache_mem_req    (req),
        .icache_mem_size   (size),
        .icache_mem_addr   (addr),
        .mem_icache_addrOK (addr_ok),
        .mem_icache_dataOK (data_ok),
        .mem_icache_data   (data),
        .ram_en            (ram_en),
        .ram_addr          (ram_addr),
        .ram_rdata         (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        ram_rdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
    end

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

    function automatic logic [LW-1:0] exp_line(input int idx);
        logic [LW-1:0] l;
        for (int k = 0; k < int'(WORDS); k++) l[32*k +: 32] = 32'hA000_0000 + 32'(idx * 4 + k);
        return l;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input int idx, input int c0);
        exp_t e;
        for (int k = 0; k < int'(WORDS); k++) begin
            e.cyc = c0 + 1 + k;
            e.val = LW'(idx * 4 + k);
            ram_q.push_back(e);
        end
        e.cyc = c0 + LAT;
        e.val = exp_line(idx);
        resp_q.push_back(e);
    endtask

    task automatic request(input logic [31:0] a, input int idx);
        @(negedge clk);
        req  = 1'b1;
        addr = a;
        #1;
        check("addrOK_accept", LW'(addr_ok), LW'(1'b1));
        push_req(idx, cyc);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("addrOK_busy", LW'(addr_ok), LW'(1'b0));
        repeat (LAT + 1) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a RAM read or a response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (ram_en) begin
                if (ram_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ram_unexpected: ram_addr %0d at cycle %0d", ram_addr, cyc);
                end else begin
                    e = ram_q.pop_front();
                    check("ram_cycle", LW'(cyc), LW'(e.cyc));
                    check("ram_addr", LW'(ram_addr), e.val);
                end
            end
            if (data_ok) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dataOK_unexpected: data %0h at cycle %0d", data, cyc);
                end else begin
                    e = resp_q.pop_front();
                    check("dataOK_cycle", LW'(cyc), LW'(e.cyc));
                    check("line_data", data, e.val);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        req  = 1'b0;
        size = 2'd2;
        addr = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_addrOK", LW'(addr_ok), '0);
        check("rst_dataOK", LW'(data_ok), '0);
        check("rst_ram_en", LW'(ram_en), '0);
        check("rst_ram_addr", LW'(ram_addr), '0);
        check("rst_data", data, '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic, unaligned, aliased and top-of-RAM lines
        size = 2'd2;
        request(32'h0000_0010, 1);
        size = 2'd0;
        request(32'h0000_001E, 1);
        size = 2'd1;
        request(32'h0000_1010, 1);
        request(32'h0000_3FF0, 255);

        // Request held high: accepted only in IDLE, once per PER cycles
        @(negedge clk);
        req  = 1'b1;
        addr = 32'h0000_0010;
        for (int i = 0; i < 3 * PER; i++) begin
            #1;
            check("held_addrOK", LW'(addr_ok), LW'((i % PER) == 0));
            if ((i % PER) == 0) push_req(1, cyc);
            @(negedge clk);
        end
        req = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        // Reset in cycle 2 of a refill
        @(negedge clk);
        req  = 1'b1;
        addr = 32'h0000_0020;
        #1;
        check("pre_rst_addrOK", LW'(addr_ok), LW'(1'b1));
        push_req(2, cyc);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        ram_q.delete();
        resp_q.delete();
        #1;
        check("mid_rst_ram_en", LW'(ram_en), '0);
        check("mid_rst_ram_addr", LW'(ram_addr), '0);
        check("mid_rst_dataOK", LW'(data_ok), '0);
        check("mid_rst_addrOK", LW'(addr_ok), '0);
        check("mid_rst_data", data, '0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (LAT + 4) @(negedge clk);
        request(32'h0000_0020, 2);

        repeat (5) @(negedge clk);
        check("ram_q_drained", LW'(ram_q.size()), '0);
        check("resp_q_drained", LW'(resp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_mem_responder.md
# icache_mem_responder

Memory-side responder for the I-cache refill interface: accepts a miss request (`icache_mem_req` + address), acknowledges it with `mem_icache_addrOK`, reads one full cache line word-by-word from a synchronous instruction RAM, and returns the line with a single-cycle `mem_icache_dataOK`. It sits between the L1 I-cache miss FSM and the instruction backing store, and serves as the refill model in cache benches.

## Interface
- `offset_width`, 2: log2(words per line); line = WORDS = 2^offset_width 32-bit words.
- `ram_addr_width`, 10: word-address width of backing RAM.
- `delay_cycles`, 3: extra wait cycles before `dataOK` (used only with `ICACHE_RESP_DELAY_EN`).
- Reset `rstn` is asynchronous, active-low; the clock is `clk`.
- `clk`  in  1  clock.
- `rstn`  in  1  async active-low reset.
- `icache_mem_req`  in  1  refill request; requester holds it high until `addrOK`.
- `icache_mem_size`  in  2  0=1B, 1=2B, 2=4B; every value is served as a full line.
- `icache_mem_addr`  in  32  byte address of the missing fetch.
- `mem_icache_addrOK`  out  1  request accepted this cycle.
- `mem_icache_dataOK`  out  1  line data valid this cycle (one-cycle pulse).
- `mem_icache_data`  out  32*WORDS  line; word k at bits [32k+31:32k].
- `ram_en`  out  1  RAM read enable.
- `ram_addr`  out  ram_addr_width  RAM word address.
- `ram_rdata`  in  32  RAM data; valid the cycle after `ram_en`.

## Operation
- States: IDLE, READ, WAIT, RESP.
- IDLE: `addrOK` = `icache_mem_req` (combinational). If req: latch line index = `addr[ram_addr_width+1 : 2+offset_width]`, clear word counter, go READ.
- READ: assert `ram_en`, `ram_addr` = {line index, cnt}. The counter increments each cycle from 0 to WORDS-1. Each `ram_rdata` is captured into word slot (cnt-1) one cycle later. After the issue of word WORDS-1, go WAIT.
- WAIT: capture the final word. Go to RESP, or go to the delay count when the macro is enabled.
- RESP: `dataOK`=1 for exactly one cycle, then go IDLE.
- `req` outside IDLE is ignored. `addrOK` stays 0 there, and no second request is queued.
- Address bits above `ram_addr_width+1` are ignored, so RAM addresses alias. Byte offset and word-offset bits are dropped because refills are always line-aligned, starting at word 0.
- `mem_icache_data` holds its last line until the next capture. It is only meaningful when `dataOK`=1.

## Timing
- Cycle 0: req in IDLE, `addrOK`=1.
- Cycles 1..WORDS: `ram_en`=1 for words 0..WORDS-1.
- Word k is captured at the end of cycle k+2.
- `dataOK` is asserted in cycle WORDS+2. With the delay enabled it is asserted in cycle WORDS+2+`delay_cycles`.
- Next acceptance: earliest in the cycle after RESP.
- Reset values: state IDLE, `addrOK`=0, `dataOK`=0, `ram_en`=0, `ram_addr`=0, `mem_icache_data`=0, counters 0.
- Reset mid-operation: immediate return to IDLE. The line is discarded and no `dataOK` is issued.
- A req that arrives in the same cycle as RESP is not accepted. It is accepted the next cycle, in IDLE.

## Configuration
- `ICACHE_RESP_DELAY_EN` defined: WAIT spends `delay_cycles` extra cycles in a down-counter before RESP. `delay_cycles`=0 is legal and gives the undelayed timing.
- Undefined: WAIT goes directly to RESP and `delay_cycles` is ignored, so no counter is synthesized.

## Structure
- Shared package `icache_mem_pkg`:
  - state encoding constants (IDLE=0, READ=1, WAIT=2, RESP=3);
  - `WORD_W`=32;
  - size codes (`SIZE_B`=0, `SIZE_H`=1, `SIZE_W`=2).
- Sub-module `icache_line_assembler`: a WORDS×32 register that takes a write-enable, a slot index and a data word, and exposes the flat line; it clears on reset.
- FSM, counters and RAM addressing stay in `icache_mem_responder`.

## Test plan
- Basic refill:
  - Stimulus: RAM word i = 0xA000_0000+i; req with addr 0x0000_0010 (line 1, WORDS=4).
  - Response: `addrOK` in cycle 0; `ram_addr` = 4,5,6,7 in cycles 1–4; `dataOK` in cycle 6; data = {0xA0000007, 0xA0000006, 0xA0000005, 0xA0000004}.
- Unaligned address:
  - Stimulus: addr 0x0000_001E.
  - Response: same line 1 returned, starting at word 4; `dataOK` still a single pulse.
- Request while busy:
  - Stimulus: req held high continuously.
  - Response: `addrOK` only in IDLE cycles. Back-to-back requests are spaced 7 cycles apart; no double response.
- Aliasing:
  - Stimulus: addr 0x0000_1010 with `ram_addr_width`=10.
  - Response: `ram_addr` 4–7, identical data to the basic refill.
- Reset mid-READ:
  - Stimulus: deassert `rstn` in cycle 2.
  - Response: all outputs 0 at once; no `dataOK`; the next req after release is served normally.
- Delay:
  - Stimulus: `ICACHE_RESP_DELAY_EN` defined with `delay_cycles`=3.
  - Response: `dataOK` in cycle 9. With `delay_cycles`=0, `dataOK` is in cycle 6.
